// File: rtl/ftdi_imit_pkg.sv
// Shared types and constants for the FTDI FT600/FT601 245-mode FIFO bench model.
//   tx_state_t / rx_state_t : FSM state encodings
//   ERR_*                   : bit positions inside oERR
//   MODE_245                : iGPIO value selecting 245 synchronous FIFO mode
package ftdi_imit_pkg;

  typedef enum logic [1:0] {
    TX_READY,
    TX_BURST,
    TX_BUSY
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_AVAIL,
    RX_DONE
  } rx_state_t;

  localparam int unsigned ERR_TX_OVERRUN = 0;
  localparam int unsigned ERR_TX_BREAK   = 1;
  localparam int unsigned ERR_CONTENTION = 2;
  localparam int unsigned ERR_MODE       = 3;
  localparam int unsigned ERR_DATA       = 4;
  localparam int unsigned ERR_W          = 5;

  localparam logic [1:0] MODE_245 = 2'b00;

endpackage

// File: rtl/ftdi_imit_rx.sv
// Host-to-FPGA (RX) side of the FTDI FIFO model.
// Holds the RX FSM, the incrementing data generator and the tri-state drive
// of the data/byte-enable bus.
//   iCLK, iRST_N : interface clock, asynchronous active-low reset
//   ioDATA, ioBE : shared bus; driven only in RX_AVAIL while iOE_N=0
//   iOE_N, iRD_N : output enable / read strobe from the FPGA
//   iRX_START    : one-cycle request to offer one RX packet (queued, depth 1)
//   oRXF_N       : low while the packet has words to offer
//   oPktDone     : one-cycle pulse on the edge that consumes the last word
module ftdi_imit_rx
  import ftdi_imit_pkg::*;
#(
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       RX_PKT_WORDS = 256,
  parameter logic [DATA_W-1:0] RX_SEED      = '0
) (
  input  logic                     iCLK,
  input  logic                     iRST_N,
  inout  wire logic [DATA_W-1:0]   ioDATA,
  inout  wire logic [DATA_W/8-1:0] ioBE,
  input  logic                     iOE_N,
  input  logic                     iRD_N,
  input  logic                     iRX_START,
  output logic                     oRXF_N,
  output logic                     oPktDone
);

  rx_state_t         rxState, rxNext;
  logic              pending, pendingNext;
  logic [DATA_W-1:0] rxData;
  logic [31:0]       rxWordCnt;
  logic              consume, lastWord, drive;

  always_comb begin
    rxNext      = rxState;
    consume     = 1'b0;
    lastWord    = 1'b0;
    // A start pulse arriving while a packet is active stays queued.
    pendingNext = pending | iRX_START;
    case (rxState)
      RX_IDLE: begin
        if (pending) begin
          rxNext      = RX_AVAIL;
          pendingNext = iRX_START;
        end
      end
      RX_AVAIL: begin
        consume  = !iRD_N && !iOE_N;
        lastWord = consume && (rxWordCnt == RX_PKT_WORDS - 1);
        if (lastWord) rxNext = RX_DONE;
      end
      RX_DONE: rxNext = RX_IDLE;
      default: rxNext = RX_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rxState   <= RX_IDLE;
      pending   <= 1'b0;
      rxData    <= RX_SEED;
      rxWordCnt <= '0;
    end else begin
      rxState <= rxNext;
      pending <= pendingNext;
      if (consume) begin
        // Data keeps counting across packets; only the word index restarts.
        rxData    <= rxData + 1'b1;
        rxWordCnt <= lastWord ? '0 : rxWordCnt + 32'd1;
      end
    end
  end

  assign oRXF_N   = (rxState != RX_AVAIL);
  assign oPktDone = lastWord;
  assign drive    = (rxState == RX_AVAIL) && !iOE_N;
  assign ioDATA   = drive ? rxData : 'z;
  assign ioBE     = drive ? '1 : 'z;

endmodule

// File: rtl/ftdi_fifo_imit.sv
// Bench model of an FTDI FT600/FT601 in 245 synchronous FIFO mode.
// Holds the TX FSM, sticky protocol-error flags and packet counters; the RX
// side lives in ftdi_imit_rx.
//   iCLK, iRST_N         : interface clock, asynchronous active-low reset
//   ioDATA, ioBE         : shared bus (FPGA drives for TX, model drives for RX)
//   oTXE_N, oRXF_N       : TX space available / RX data available (active low)
//   iOE_N, iRD_N, iWR_N  : FPGA strobes
//   iGPIO                : mode select, must be MODE_245
//   iRX_START            : queue one RX packet
//   oTX_PKT_CNT/oRX_PKT_CNT : completed packets, wrapping
//   oERR                 : sticky error flags, see ERR_* in ftdi_imit_pkg
// Optional: define FTDI_IMIT_CHECK_EN to compare TX words against an
// incrementing pattern (oERR[4]) and print per-packet log lines.
module ftdi_fifo_imit
  import ftdi_imit_pkg::*;
#(
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       TX_PKT_WORDS = 1024,
  parameter int unsigned       TX_BUSY_CLK  = 10000,
  parameter int unsigned       RX_PKT_WORDS = 256,
  parameter logic [DATA_W-1:0] RX_SEED      = '0
) (
  input  logic                     iCLK,
  input  logic                     iRST_N,
  inout  wire logic [DATA_W-1:0]   ioDATA,
  inout  wire logic [DATA_W/8-1:0] ioBE,
  output logic                     oTXE_N,
  output logic                     oRXF_N,
  input  logic                     iOE_N,
  input  logic                     iRD_N,
  input  logic                     iWR_N,
  input  logic [1:0]               iGPIO,
  input  logic                     iRX_START,
  output logic [15:0]              oTX_PKT_CNT,
  output logic [15:0]              oRX_PKT_CNT,
  output logic [ERR_W-1:0]         oERR
);

  localparam int unsigned BE_W = DATA_W / 8;

  if (DATA_W != 16 && DATA_W != 32) begin : gBadWidth
    $fatal(1, "ftdi_fifo_imit: DATA_W must be 16 or 32");
  end

  tx_state_t        txState, txNext;
  logic [31:0]      txWordCnt, busyCnt;
  logic             txAccept, txLast, rxDone;
  logic [15:0]      txPktCnt, rxPktCnt;
  logic [ERR_W-1:0] errReg, errSet;

  ftdi_imit_rx #(
    .DATA_W      (DATA_W),
    .RX_PKT_WORDS(RX_PKT_WORDS),
    .RX_SEED     (RX_SEED)
  ) uRx (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .ioDATA   (ioDATA),
    .ioBE     (ioBE),
    .iOE_N    (iOE_N),
    .iRD_N    (iRD_N),
    .iRX_START(iRX_START),
    .oRXF_N   (oRXF_N),
    .oPktDone (rxDone)
  );

`ifdef FTDI_IMIT_CHECK_EN
  logic [DATA_W-1:0] txExp;
  logic              dataBad;

  always_comb begin
    dataBad = 1'b0;
    for (int unsigned b = 0; b < BE_W; b++) begin
      if (ioBE[b] && (ioDATA[8*b +: 8] != txExp[8*b +: 8])) dataBad = 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) txExp <= '0;
    else if (txAccept) txExp <= txExp + 1'b1;
  end

  always_ff @(posedge iCLK) begin
    if (iRST_N) begin
      if (txAccept && dataBad)
        $display("ftdi_imit: %0t tx data error, expected %h received %h",
                 $time, txExp, ioDATA);
      if (txLast) $display("ftdi_imit: %0t tx packet %0d complete", $time, txPktCnt + 16'd1);
      if (rxDone) $display("ftdi_imit: %0t rx packet %0d complete", $time, rxPktCnt + 16'd1);
    end
  end
`endif

  // TXE_N is high exactly while the host is draining a full packet.
  assign oTXE_N = (txState == TX_BUSY);

  always_comb begin
    txAccept = !iWR_N && !oTXE_N;
    txLast   = txAccept && (txWordCnt == TX_PKT_WORDS - 1);
    txNext   = txState;
    case (txState)
      TX_READY: begin
        if (txLast) txNext = TX_BUSY;
        else if (txAccept) txNext = TX_BURST;
      end
      TX_BURST: if (txLast) txNext = TX_BUSY;
      TX_BUSY:  if (busyCnt == '0) txNext = TX_READY;
      default:  txNext = TX_READY;
    endcase

    errSet = '0;
    errSet[ERR_TX_OVERRUN] = !iWR_N && oTXE_N;
    errSet[ERR_TX_BREAK]   = iWR_N && (txState == TX_BURST);
    // Write colliding with a read-side strobe, or a read with nothing offered.
    errSet[ERR_CONTENTION] = (!iWR_N && (!iOE_N || !iRD_N)) || (!iRD_N && oRXF_N);
    errSet[ERR_MODE]       = (iGPIO != MODE_245);
`ifdef FTDI_IMIT_CHECK_EN
    errSet[ERR_DATA]       = txAccept && dataBad;
`endif
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      txState   <= TX_READY;
      txWordCnt <= '0;
      busyCnt   <= '0;
      txPktCnt  <= '0;
      rxPktCnt  <= '0;
      errReg    <= '0;
    end else begin
      txState <= txNext;
      errReg  <= errReg | errSet;
      if (txLast) begin
        txWordCnt <= '0;
        busyCnt   <= TX_BUSY_CLK - 1;
        txPktCnt  <= txPktCnt + 16'd1;
      end else if (txAccept) begin
        txWordCnt <= txWordCnt + 32'd1;
      end
      if (txState == TX_BUSY && busyCnt != '0) busyCnt <= busyCnt - 32'd1;
      if (rxDone) rxPktCnt <= rxPktCnt + 16'd1;
    end
  end

  assign oTX_PKT_CNT = txPktCnt;
  assign oRX_PKT_CNT = rxPktCnt;
  assign oERR        = errReg;

endmodule
